// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter for 16 requesters sharing a one-hot select bus.
// Grants are held until release or HOLD_MAX expiry, with one idle turnaround cycle between grants.
module onehot_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic        grant_valid,
  output logic [3:0]  grant_code,
  output logic [15:0] grant_onehot,
  output logic        expired,
  output logic [7:0]  grant_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t      state, state_next;
  logic [3:0]  ptr, ptr_next;
  logic [3:0]  gidx, gidx_next;
  logic [7:0]  hold, hold_next;
  logic [3:0]  pick;
  logic        pick_found;
  logic        valid_next;
  logic        expired_next;
  logic [3:0]  code_next;
  logic [15:0] onehot_next;
  logic [7:0]  count_next;

  // Rotating-priority search; scanning offsets downward leaves the nearest one to ptr.
  always_comb begin
    pick       = 4'd0;
    pick_found = |req;
    for (int i = 15; i >= 0; i--) begin
      pick = req[ptr + 4'(i)] ? (ptr + 4'(i)) : pick;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    gidx_next    = gidx;
    hold_next    = hold;
    valid_next   = grant_valid;
    code_next    = grant_code;
    onehot_next  = grant_onehot;
    expired_next = 1'b0;
    count_next   = grant_count;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next  = GRANT;
          gidx_next   = pick;
          hold_next   = 8'd1;
          valid_next  = 1'b1;
          code_next   = 4'd7 - pick;
          onehot_next = 16'd1 << pick;
          count_next  = grant_count + 8'd1;
        end else begin
          valid_next  = 1'b0;
          onehot_next = 16'h0000;
        end
      end
      GRANT: begin
        if (!req[gidx]) begin
          state_next  = IDLE;
          valid_next  = 1'b0;
          onehot_next = 16'h0000;
          ptr_next    = gidx + 4'd1;
        end else if ((HOLD_LIM != 8'd0) && (hold == HOLD_LIM)) begin
          state_next   = IDLE;
          valid_next   = 1'b0;
          onehot_next  = 16'h0000;
          ptr_next     = gidx + 4'd1;
          expired_next = 1'b1;
        end else begin
          hold_next = (hold == 8'hFF) ? hold : (hold + 8'd1);
        end
      end
      default: begin
        state_next  = IDLE;
        valid_next  = 1'b0;
        onehot_next = 16'h0000;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 4'd0;
      gidx         <= 4'd0;
      hold         <= 8'd0;
      grant_valid  <= 1'b0;
      grant_code   <= 4'b0000;
      grant_onehot <= 16'h0000;
      expired      <= 1'b0;
      grant_count  <= 8'd0;
    end else begin
      state        <= state_next;
      ptr          <= ptr_next;
      gidx         <= gidx_next;
      hold         <= hold_next;
      grant_valid  <= valid_next;
      grant_code   <= code_next;
      grant_onehot <= onehot_next;
      expired      <= expired_next;
      grant_count  <= count_next;
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Randomized bench for onehot_rr_arbiter: three instances (HOLD_MAX 4, 0, 8) compared
// every cycle against a behavioural model, plus directed boundary checks.
module tb_onehot_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = 16'h0000;

  logic        v  [3];
  logic [3:0]  c  [3];
  logic [15:0] oh [3];
  logic        e  [3];
  logic [7:0]  n  [3];

  int lim [3] = '{4, 0, 8};
  int total = 0;
  int bad   = 0;

  // model state: granted index (-1 = none), hold cycles, search start, grants, last code
  int m_g [3], m_hold [3], m_ptr [3], m_cnt [3], m_code [3];
  bit m_exp [3];

  always #5 clk = ~clk;

  onehot_rr_arbiter #(.HOLD_MAX(4)) dut4 (.clk(clk), .rst(rst), .req(req), .grant_valid(v[0]),
    .grant_code(c[0]), .grant_onehot(oh[0]), .expired(e[0]), .grant_count(n[0]));
  onehot_rr_arbiter #(.HOLD_MAX(0)) dut0 (.clk(clk), .rst(rst), .req(req), .grant_valid(v[1]),
    .grant_code(c[1]), .grant_onehot(oh[1]), .expired(e[1]), .grant_count(n[1]));
  onehot_rr_arbiter dut8 (.clk(clk), .rst(rst), .req(req), .grant_valid(v[2]),
    .grant_code(c[2]), .grant_onehot(oh[2]), .expired(e[2]), .grant_count(n[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_g[k] = -1; m_hold[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_code[k] = 0; m_exp[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      m_exp[k] = 1'b0;
      if (m_g[k] < 0) begin
        for (int i = 0; i < 16; i++) begin
          int b;
          b = (m_ptr[k] + i) % 16;
          if (m_g[k] < 0 && req[b]) begin
            m_g[k]    = b;
            m_hold[k] = 1;
            m_cnt[k]  = (m_cnt[k] + 1) % 256;
            m_code[k] = (7 - b + 16) % 16;
          end
        end
      end else if (!req[m_g[k]]) begin
        m_ptr[k] = (m_g[k] + 1) % 16;
        m_g[k]   = -1;
      end else if (lim[k] != 0 && m_hold[k] == lim[k]) begin
        m_ptr[k] = (m_g[k] + 1) % 16;
        m_g[k]   = -1;
        m_exp[k] = 1'b1;
      end else if (m_hold[k] < 255) begin
        m_hold[k]++;
      end
    end
  endtask

  function automatic logic [31:0] want_vec(input int k);
    logic [15:0] o;
    o = (m_g[k] >= 0) ? (16'd1 << m_g[k]) : 16'h0000;
    return {2'b00, (m_g[k] >= 0), 4'(m_code[k]), o, m_exp[k], 8'(m_cnt[k])};
  endfunction

  function automatic logic [31:0] got_vec(input int k);
    return {2'b00, v[k], c[k], oh[k], e[k], n[k]};
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) check($sformatf("hold%0d", lim[k]), got_vec(k), want_vec(k));
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
    end
  endtask

  // reset pulse placed between edges; outputs must clear without a clock edge
  task automatic mid_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all();
    for (int k = 0; k < 3; k++) check("rst_zero", got_vec(k), 32'h0000_0000);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    rst = 1'b0;

    // bit0 -> code +7
    req = 16'h0001; tick(1);
    check("code_bit0", {28'd0, c[2]}, 32'h7);
    check("oh_bit0", {16'd0, oh[2]}, 32'h0001);
    check("cnt_first", {24'd0, n[2]}, 32'h1);
    req = 16'h0000; tick(2);

    // bit15 -> code -8, release gives no expiry
    req = 16'h8000; tick(1);
    check("code_bit15", {28'd0, c[2]}, 32'h8);
    req = 16'h0000; tick(1);
    check("rel_valid", {31'd0, v[2]}, 32'h0);
    check("rel_exp", {31'd0, e[2]}, 32'h0);

    // alternating expiry on two constant requesters
    req = 16'h8001; tick(16);

    // release on the same cycle the hold limit is reached
    req = 16'h0000; tick(2);
    req = 16'h0002; tick(4);
    req = 16'h0000; tick(1);
    check("rel_at_lim_valid", {31'd0, v[0]}, 32'h0);
    check("rel_at_lim_exp", {31'd0, e[0]}, 32'h0);
    tick(1);

    // reset during a grant to bit 3, then restart from ptr 0
    req = 16'h0008; tick(2);
    req = 16'h0FFF; tick(1);
    mid_reset();
    tick(1);
    check("post_rst_code", {28'd0, c[2]}, 32'h7);

    // unlimited hold
    req = 16'h0000; tick(1);
    mid_reset();
    req = 16'h0004; tick(300);
    check("unl_valid", {31'd0, v[1]}, 32'h1);
    check("unl_code", {28'd0, c[1]}, 32'h5);
    check("unl_cnt", {24'd0, n[1]}, 32'h1);

    // randomized traffic with occasional resets
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 3) == 0) req = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 255) == 0) mid_reset();
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter that shares one 16-way one-hot select bus among 16 requesters.
- Holds each grant until the requester releases, or until a programmable hold limit expires.
- Outputs the grant as a 4-bit two's-complement slot code for the team's one-hot decoder, plus a registered one-hot copy.
- Slot code mapping (fixed, matches the decoder):
  - Code 4'b1000 (-8) selects bit 15; code 4'b0111 (+7) selects bit 0.
  - Code = 7 - bit_index, taken modulo 16.

Parameters:
- HOLD_MAX, 8: maximum consecutive cycles one grant may be held. 0 = unlimited. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  request lines; req[b] high = requester b wants the bus.
- grant_valid  output  1  a grant is active this cycle.
- grant_code  output  4  signed slot code of the granted requester (7 - b mod 16).
- grant_onehot  output  16  one-hot of the granted bit; all zero when grant_valid=0.
- expired  output  1  one-cycle pulse: the grant was revoked by the HOLD_MAX limit.
- grant_count  output  8  number of grants issued since reset; wraps 255->0.

Behaviour:
- Reset values (asynchronous, take effect immediately on rst):
  - grant_valid=0, grant_code=4'b0000, grant_onehot=16'h0000, expired=0, grant_count=0.
  - State=IDLE, search pointer ptr=0, hold counter=0.
- All outputs are registered.
- State IDLE:
  - If req==0: stay in IDLE, outputs unchanged except grant_onehot=0.
  - Else select the first set req bit scanning ascending bit index from ptr, wrapping 15->0.
  - Next cycle: state=GRANT, grant_valid=1, grant_code=7-b, grant_onehot=1<<b, hold counter=1, grant_count+1.
  - Latency from sampled req to grant_valid: 1 cycle.
- State GRANT (granted bit g):
  - Release: req[g]==0 sampled -> next cycle IDLE, grant_valid=0, grant_onehot=0, ptr=(g+1) mod 16.
  - Expiry: HOLD_MAX!=0, hold counter==HOLD_MAX, and req[g] still 1 -> next cycle IDLE, grant_valid=0, expired=1 for exactly one cycle, ptr=(g+1) mod 16.
  - Otherwise: stay in GRANT, hold counter+1, saturating at 255 when HOLD_MAX=0.
  - Release and expiry in the same cycle count as a release: expired stays 0.
- Every grant is followed by at least one IDLE cycle with grant_valid=0 (bus turnaround). Back-to-back grant_valid is never asserted across two different grants.
- grant_code holds its last value while in IDLE and is only meaningful while grant_valid=1.
- Changes on req bits other than g during GRANT are ignored until the next IDLE.
- A request that rises and falls entirely within a GRANT period is never granted; there is no request latching.
- Invariant: popcount(grant_onehot) is 0 or 1, and is 1 iff grant_valid=1.
- Reset asserted mid-grant clears the grant immediately, without waiting for a clock edge. Arbitration after release of rst restarts from ptr=0.

Test Plan:
- Reset then req=16'h0001 -> after 1 clk: grant_valid=1, grant_code=4'b0111, grant_onehot=16'h0001, grant_count=1.
- req=16'h8000 from IDLE -> grant_code=4'b1000 (-8), grant_onehot=16'h8000. Drop req -> next cycle grant_valid=0, expired=0.
- HOLD_MAX=4, req=16'h8001 held constant -> bit0 granted 4 cycles, expired pulse, 1 idle cycle, bit15 granted 4 cycles, expired, 1 idle, bit0 again; grant_count increments 1,2,3.
- HOLD_MAX=4, req[g] dropped in the same cycle the counter reaches 4 -> grant_valid=0 next cycle, expired=0.
- Grant to bit 3 active, req=16'h0FFF -> rst pulse mid-cycle -> outputs zero before the next edge; after rst release the first grant goes to bit0 (code 4'b0111).
- HOLD_MAX=0, req=16'h0004 held 300 cycles -> grant_valid stays 1 (code 4'b0101), no expired pulse, grant_count stays 1.
